axil_regfile_slave: RTL and testbench

Parametrised successor to the fixed 3-bit-address, 4-bit-data demo slave: a register-file slave on an AXI-Lite-style five-channel handshake (AW, W, B, AR, R) with configurable data width and register count, plus a response code on B and R. It sits between the on-chip master and the board I/O wrapper. A registered monitor port lets the wrapper drive the 7-segment display from any register without touching the bus.

---
 rtl/axil_pkg.sv | 7 +
 rtl/axil_reg_array.sv | 30 +++
 rtl/axil_regfile_slave.sv | 113 +++++++++++
 tb/tb_axil_regfile_slave.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// axil_pkg: response codes and FSM state types shared by the register-file slave
package axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
endpackage

// File: rtl/axil_reg_array.sv
// axil_reg_array: NUM_REGS x DATA_W registers, one write port, two registered read ports
module axil_reg_array #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] mon_addr,
  output logic [DATA_W-1:0] mon_data
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  // Indices past the implemented range read as zero and are never written
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rd_data  <= '0;
      mon_data <= '0;
    end else begin
      if (we && 32'(waddr) < NUM_REGS) regs[waddr] <= wdata;
      if (rd_en) rd_data <= 32'(rd_addr) < NUM_REGS ? regs[rd_addr] : '0;
      mon_data <= 32'(mon_addr) < NUM_REGS ? regs[mon_addr] : '0;
    end
endmodule

// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI-Lite style register-file slave; AXIL_SLVERR_EN selects SLVERR over address aliasing
module axil_regfile_slave #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [1:0]        b_resp,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ADDR_W-1:0] ar_addr,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  input  logic [ADDR_W-1:0] mon_addr,
  output logic [DATA_W-1:0] mon_data
);
  import axil_pkg::*;
  wstate_t ws;
  rstate_t rs;
  logic aw_held, w_held, aw_fire, w_fire, ar_fire, commit, we;
  logic [ADDR_W-1:0] aw_q, waddr, arr_waddr, arr_raddr;
  logic [DATA_W-1:0] w_q, wdata;
  logic [1:0] wresp, rresp;
  assign aw_ready = ws == W_COLLECT && !aw_held;
  assign w_ready  = ws == W_COLLECT && !w_held;
  assign ar_ready = rs == R_IDLE;
  assign b_valid  = ws == W_RESP;
  assign r_valid  = rs == R_DATA;
  assign aw_fire  = aw_valid && aw_ready;
  assign w_fire   = w_valid && w_ready;
  assign ar_fire  = ar_valid && ar_ready;
  // Commit on the edge where both halves are present, held or arriving now
  assign commit   = ws == W_COLLECT && (aw_held || aw_fire) && (w_held || w_fire);
  assign waddr    = aw_held ? aw_q : aw_addr;
  assign wdata    = w_held ? w_q : w_data;
`ifdef AXIL_SLVERR_EN
  logic w_ok, r_ok;
  assign w_ok      = 32'(waddr) < NUM_REGS;
  assign r_ok      = 32'(ar_addr) < NUM_REGS;
  assign arr_waddr = waddr;
  assign arr_raddr = ar_addr;
  assign we        = commit && w_ok;
  assign wresp     = w_ok ? RESP_OKAY : RESP_SLVERR;
  assign rresp     = r_ok ? RESP_OKAY : RESP_SLVERR;
`else
  assign arr_waddr = ADDR_W'(32'(waddr) % NUM_REGS);
  assign arr_raddr = ADDR_W'(32'(ar_addr) % NUM_REGS);
  assign we        = commit;
  assign wresp     = RESP_OKAY;
  assign rresp     = RESP_OKAY;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ws      <= W_COLLECT;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_q    <= '0;
      w_q     <= '0;
      b_resp  <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_q    <= aw_addr;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_q    <= w_data;
      end
      if (commit) begin
        ws     <= W_RESP;
        b_resp <= wresp;
      end
      if (ws == W_RESP && b_ready) begin
        ws      <= W_COLLECT;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rs     <= R_IDLE;
      r_resp <= RESP_OKAY;
    end else begin
      if (ar_fire) begin
        rs     <= R_DATA;
        r_resp <= rresp;
      end
      if (rs == R_DATA && r_ready) rs <= R_IDLE;
    end
  axil_reg_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (arr_waddr),
    .wdata    (wdata),
    .rd_en    (ar_fire),
    .rd_addr  (arr_raddr),
    .rd_data  (r_data),
    .mon_addr (mon_addr),
    .mon_data (mon_data)
  );
endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb_axil_regfile_slave: randomized and directed checks against an array model of the register file
module tb_axil_regfile_slave;
  localparam int NREGS = 6;
  logic clk = 0, rst_n = 0;
  logic aw_valid = 0, w_valid = 0, ar_valid = 0, b_ready = 0, r_ready = 0;
  logic [2:0] aw_addr = 0, ar_addr = 0, mon_addr = 0;
  logic [7:0] w_data = 0;
  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [1:0] b_resp, r_resp;
  logic [7:0] r_data, mon_data;
  int n_chk = 0, n_bad = 0;
  logic [7:0] mdl [NREGS];

  axil_regfile_slave #(.ADDR_W(3), .DATA_W(8), .NUM_REGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .mon_addr(mon_addr), .mon_data(mon_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int eidx(input int a);
`ifdef AXIL_SLVERR_EN
    return a;
`else
    return a % NREGS;
`endif
  endfunction

  function automatic logic [1:0] eresp(input int a);
`ifdef AXIL_SLVERR_EN
    return a < NREGS ? 2'b00 : 2'b10;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [7:0] eread(input int a);
    return eidx(a) < NREGS ? mdl[eidx(a)] : 8'h00;
  endfunction

  task automatic mwrite(input int a, input logic [7:0] d);
    if (eidx(a) < NREGS) mdl[eidx(a)] = d;
  endtask

  task automatic mclear();
    for (int i = 0; i < NREGS; i++) mdl[i] = 8'h00;
  endtask

  task automatic chk_mon(input int a);
    mon_addr = 3'(a);
    @(negedge clk);
    chk("mon_data", mon_data, a < NREGS ? mdl[a] : 8'h00);
  endtask

  // AW and W each go valid after their own delay; B is stalled for 'stall' cycles
  task automatic do_write(input int a, input logic [7:0] d, input int da, input int dw, input int stall);
    int t = 0;
    bit ad = 0, wd = 0, fa, fw;
    logic [1:0] resp0;
    while (!(ad && wd) && t < 50) begin
      aw_valid = !ad && t >= da;
      aw_addr = 3'(a);
      w_valid = !wd && t >= dw;
      w_data = d;
      #1;
      fa = aw_valid && aw_ready;
      fw = w_valid && w_ready;
      @(negedge clk);
      ad |= fa;
      wd |= fw;
      t++;
      if (ad != wd) chk("held_ready", {30'd0, aw_ready, w_ready}, {30'd0, !ad, !wd});
    end
    aw_valid = 0;
    w_valid = 0;
    if (t >= 50) begin
      chk("write_accept_timeout", 0, 1);
      return;
    end
    mwrite(a, d);
    chk("b_valid", b_valid, 1);
    chk("b_resp", b_resp, eresp(a));
    resp0 = b_resp;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("b_hold", {29'd0, b_valid, b_resp}, {29'd0, 1'b1, resp0});
      chk("wr_ready_low", {30'd0, aw_ready, w_ready}, 0);
    end
    b_ready = 1;
    @(negedge clk);
    b_ready = 0;
    chk("b_done", {29'd0, b_valid, aw_ready, w_ready}, 3'b011);
  endtask

  task automatic do_read(input int a, input int stall);
    logic [7:0] d0;
    ar_valid = 1;
    ar_addr = 3'(a);
    #1;
    chk("ar_ready", ar_ready, 1);
    @(negedge clk);
    ar_valid = 0;
    chk("r_valid", r_valid, 1);
    chk("r_data", r_data, eread(a));
    chk("r_resp", r_resp, eresp(a));
    d0 = r_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("r_hold", {23'd0, r_valid, r_data}, {23'd0, 1'b1, d0});
      chk("ar_ready_low", ar_ready, 0);
    end
    r_ready = 1;
    @(negedge clk);
    r_ready = 0;
    chk("r_done", {30'd0, r_valid, ar_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    mclear();
    #3;
    chk("rst_valids", {30'd0, b_valid, r_valid}, 0);
    chk("rst_readies", {29'd0, aw_ready, w_ready, ar_ready}, 3'b111);
    chk("rst_r_data", r_data, 0);
    chk("rst_mon", mon_data, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_write(2, 8'hA5, 0, 0, 0);
    do_read(2, 0);
    do_write(4, 8'h3C, 3, 0, 0);
    chk_mon(4);
    do_write(0, 8'h5E, 0, 1, 5);
    do_read(0, 5);
    do_write(1, 8'h77, 0, 0, 0);
    // write and read of index 1 accepted on the same edge
    aw_valid = 1; aw_addr = 1; w_valid = 1; w_data = 8'h11;
    ar_valid = 1; ar_addr = 1;
    @(negedge clk);
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    chk("same_edge_r", r_data, eread(1));
    chk("same_edge_b", {30'd0, b_valid, r_valid}, 2'b11);
    mwrite(1, 8'h11);
    b_ready = 1; r_ready = 1;
    @(negedge clk);
    b_ready = 0; r_ready = 0;
    do_read(1, 0);
    chk("after_same_edge", mdl[1], 8'h11);
    do_write(7, 8'hC3, 1, 0, 1);
    for (int i = 0; i < 8; i++) chk_mon(i);
    do_read(7, 1);
    for (int it = 0; it < 60; it++) begin
      int op, a;
      op = $urandom_range(0, 2);
      a = $urandom_range(0, 7);
      if (op == 0) do_write(a, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else if (op == 1) do_read(a, $urandom_range(0, 2));
      chk_mon($urandom_range(0, 7));
    end
    // reset while both channels hold a pending response
    aw_valid = 1; aw_addr = 3; w_valid = 1; w_data = 8'h5A;
    ar_valid = 1; ar_addr = 2;
    @(negedge clk);
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    chk("pre_rst_valids", {30'd0, b_valid, r_valid}, 2'b11);
    #2 rst_n = 0;
    #1;
    chk("rst_async_valids", {30'd0, b_valid, r_valid}, 0);
    chk("rst_async_ready", {29'd0, aw_ready, w_ready, ar_ready}, 3'b111);
    chk("rst_async_rdata", r_data, 0);
    mclear();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < NREGS; i++) chk_mon(i);
    do_read(5, 0);
    do_write(3, 8'h99, 0, 2, 0);
    do_read(3, 0);
    chk_mon(3);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
